prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//   Receive-side counterpart of the PRBS generator. Sits after the CDR and is
//   clocked by the recovered clock; it takes the retimed serial bit stream,
//   self-seeds a local LFSR from the incoming data, and declares lock. Once
//   locked, it compares every bit against the local prediction and reports
//   per-bit errors, a saturating error count and loss of lock.
// PARAMETERS
//   ORDER        7    LFSR length. The polynomial is x^ORDER + x^TAP + 1, the same as the generator.
//   TAP          6    Second feedback tap. Feedback fb = lfsr[ORDER-1] ^ lfsr[TAP-1].
//   LOCK_CNT     16   Number of consecutive matching bits in HUNT needed to assert lock.
//   WINDOW       64   Length, in bits, of the loss-of-lock observation window in LOCK.
//   LOSS_THRESH  4    Errors within one window that force a re-seed.
//   ERR_W        16   Width of err_cnt.
// PORTS
//   rx_clk    in   1      Recovered clock (the CDR clk_out). All logic is posedge rx_clk.
//   rst       in   1      Asynchronous reset, active-low (0 = reset).
//   data_in   in   1      Retimed serial data (the CDR data_out).
//   en        in   1      Bit qualifier. When en=0, the block holds all state.
//   clr_cnt   in   1      Synchronous clear of err_cnt.
//   locked    out  1      1 while the FSM is in LOCK.
//   err       out  1      One-cycle pulse: the bit sampled in LOCK mismatched the prediction.
//   err_cnt   out  ERR_W  Saturating count of errors taken in LOCK.
// BEHAVIOUR
//   Reset (rst=0, asynchronous): state=SEED, lfsr=0, seed_cnt=0, match_cnt=0,
//     win_cnt=0, err_win=0, locked=0, err=0, err_cnt=0. All outputs are registered.
//   Only cycles with en=1 advance any counter, the LFSR or the FSM.
//   Prediction pred = lfsr[ORDER-1] ^ lfsr[TAP-1]. The shift is lfsr <= {lfsr[ORDER-2:0], x}.
//   SEED: x=data_in. seed_cnt counts to ORDER.
//     - On the ORDER-th bit, the next state is HUNT with match_cnt=0.
//     - If the seeded value would be all-zero (stuck-low input), stay in SEED
//       with seed_cnt=0. The LFSR lock-up state is never used.
//   HUNT: x=pred (free-running).
//     - data_in==pred: match_cnt++. On reaching LOCK_CNT, go to LOCK with win_cnt=0 and err_win=0.
//     - data_in!=pred: go to SEED with seed_cnt=0. No err pulse and no count.
//   LOCK: x=pred (the stream never re-seeds the LFSR while locked).
//     - Mismatch: err=1 in the next cycle (latency 1 from the sampling edge), err_cnt++, err_win++.
//     - win_cnt counts 0..WINDOW-1 and then wraps. On the wrap bit, err_win restarts at
//       0, or at 1 if that bit is itself an error.
//     - If err_win reaches LOSS_THRESH, go to SEED. locked falls in the same update as the
//       state change. That final error is still pulsed and counted.
//   locked is 1 exactly when state==LOCK.
//   err is 0 in every cycle where the previous en=1 bit was not a LOCK mismatch, including en=0 cycles.
//   err_cnt saturates at 2^ERR_W-1.
//     - clr_cnt=1 sets err_cnt to 0 and takes priority over a simultaneous increment.
//     - clr_cnt acts regardless of en and does not affect the FSM.
//   Asserting rst mid-stream (any state) returns everything to the reset values at once.
//     Re-acquisition then takes ORDER+LOCK_CNT good bits.
// TESTING
//   1. Reset is released. The generator runs PRBS7 with en=1 held, and the stream is error-free ->
//      locked rises after exactly 7+16=23 bits. err stays 0 and err_cnt stays 0 for 1000 bits.
//   2. Lock is held. One bit is inverted at bit 200 -> err pulses once, exactly one cycle after
//      that bit. err_cnt=1 and locked stays 1.
//   3. Lock is held. Four bits are inverted inside one 64-bit window -> err_cnt=4 and locked falls
//      after the 4th error. The stream is then restored -> locked rises again 23 bits later.
//   4. Lock is held. 3 errors land in one window and 3 in the next window -> locked stays 1 and
//      err_cnt=6.
//   5. data_in is held at 0 for 100 bits -> the FSM stays in SEED. locked=0 and err_cnt does not
//      change. A valid PRBS7 stream then follows -> lock.
//   6. ERR_W=4 is set, and 20 errors are forced while locked with LOSS_THRESH raised ->
//      err_cnt=15. clr_cnt is pulsed in the same cycle as an error -> err_cnt=0.
//      rst=0 is driven mid-LOCK -> locked=0 at once.

Source files
------------

// File: rtl/prbs_checker_if.sv
// Serial PRBS receive interface: qualified bit stream in, lock/error status out.
// Latency: none (wires only).
// Backpressure: none; en qualifies each bit and the checker never stalls the source.
interface prbs_checker_if #(
  parameter int ERR_W = 16
);
  logic             data_in;
  logic             en;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  // Source side: the CDR/bench drives bits and watches status.
  modport master (
    output data_in, en, clr_cnt,
    input  locked, err, err_cnt
  );

  // Checker side.
  modport slave (
    input  data_in, en, clr_cnt,
    output locked, err, err_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-seeding PRBS checker: seeds a local LFSR from the stream, locks, then flags bit errors.
// Latency: err/err_cnt/locked are registered, 1 cycle after the sampling edge of the bit.
// Backpressure: none; en=0 freezes all state, clr_cnt acts every cycle.
module prbs_checker #(
  parameter int ORDER       = 7,
  parameter int TAP         = 6,
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input logic          rx_clk,
  input logic          rst,
  prbs_checker_if.slave bus
);

  localparam int SC_W = $clog2(ORDER + 1);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW_W = $clog2(LOSS_THRESH + 1);

  localparam logic [SC_W-1:0]  SEED_LAST  = SC_W'(ORDER - 1);
  localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [WC_W-1:0]  WIN_LAST   = WC_W'(WINDOW - 1);
  localparam logic [EW_W-1:0]  LOSS_C     = EW_W'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state;
  logic [ORDER-1:0] lfsr;
  logic [SC_W-1:0]  seed_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic [WC_W-1:0]  win_cnt;
  logic [EW_W-1:0]  err_win;
  logic             locked_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             pred;
  logic             mismatch;
  logic [ORDER-1:0] seed_val;
  logic             win_wrap;
  logic [EW_W-1:0]  err_win_nxt;
  logic             lock_err;

  // Local prediction of the current bit and its comparison with the line.
  assign pred     = lfsr[ORDER-1] ^ lfsr[TAP-1];
  assign mismatch = bus.data_in ^ pred;

  // LFSR contents if the current line bit is shifted in (seeding path).
  assign seed_val = {lfsr[ORDER-2:0], bus.data_in};

  // The wrap bit opens a new window, so its own error (if any) is its first entry.
  assign win_wrap    = (win_cnt == WIN_LAST);
  assign err_win_nxt = win_wrap ? EW_W'(mismatch) : (err_win + EW_W'(mismatch));

  // A countable error: a qualified bit sampled in LOCK that disagrees with the prediction.
  assign lock_err = bus.en && (state == ST_LOCK) && mismatch;

  // Acquisition/tracking FSM with window bookkeeping and the registered err pulse.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SEED;
      lfsr      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      err_win   <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        case (state)
          ST_SEED: begin
            lfsr <= seed_val;
            if (seed_cnt == SEED_LAST) begin
              seed_cnt <= '0;
              // An all-zero seed would lock the LFSR up; keep seeding instead.
              if (seed_val != '0) begin
                state     <= ST_HUNT;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SC_W'(1);
            end
          end

          ST_HUNT: begin
            lfsr <= {lfsr[ORDER-2:0], pred};
            if (!mismatch) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= ST_LOCK;
                locked_q  <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                err_win   <= '0;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else begin
              // Bad seed: start over silently, nothing is reported while hunting.
              state     <= ST_SEED;
              seed_cnt  <= '0;
              match_cnt <= '0;
            end
          end

          ST_LOCK: begin
            // Free-running: the line never feeds the LFSR while locked.
            lfsr    <= {lfsr[ORDER-2:0], pred};
            err_q   <= mismatch;
            win_cnt <= win_wrap ? '0 : (win_cnt + WC_W'(1));
            if (err_win_nxt >= LOSS_C) begin
              state    <= ST_SEED;
              locked_q <= 1'b0;
              seed_cnt <= '0;
              err_win  <= '0;
            end else begin
              err_win <= err_win_nxt;
            end
          end

          default: begin
            state    <= ST_SEED;
            locked_q <= 1'b0;
            seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; clear wins over increment and ignores en.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      err_cnt_q <= '0;
    end else if (lock_err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  localparam int ORDER    = 7;
  localparam int TAP      = 6;
  localparam int LOCK_CNT = 16;
  localparam int WINDOW   = 64;
  localparam int LOSS     = 4;
  localparam int ERR_W    = 4;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic rx_clk;
  logic rst;

  prbs_checker_if #(.ERR_W(ERR_W)) bus ();

  prbs_checker #(
    .ORDER(ORDER), .TAP(TAP), .LOCK_CNT(LOCK_CNT),
    .WINDOW(WINDOW), .LOSS_THRESH(LOSS), .ERR_W(ERR_W)
  ) dut (
    .rx_clk(rx_clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transmit-side PRBS: recent history of sent bits, s[n] = s[n-ORDER] ^ s[n-TAP].
  bit g_hist[$];
  int g_pend;

  // Reference receiver: recent local sequence plus plain counters.
  bit m_q[$];
  int m_mode;     // 0 seeding, 1 hunting, 2 locked
  int m_cnt;      // bits taken in the current seed / hunt attempt
  int m_win;      // position of the next bit inside the current window
  int m_werr;     // errors charged to the current window
  int exp_cnt;
  bit exp_err;
  bit exp_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_seed();
    int v;
    v = $urandom_range(1, (1 << ORDER) - 1);
    g_hist.delete();
    for (int i = 0; i < ORDER; i++) g_hist.push_back(v[i]);
    g_pend = ORDER;
  endtask

  task automatic gen_next(output bit b);
    if (g_pend > 0) begin
      b = g_hist[ORDER - g_pend];
      g_pend--;
    end else begin
      b = g_hist[g_hist.size() - ORDER] ^ g_hist[g_hist.size() - TAP];
      g_hist.push_back(b);
      void'(g_hist.pop_front());
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_cnt = 0; m_win = 0; m_werr = 0;
    exp_cnt = 0; exp_err = 1'b0; exp_locked = 1'b0;
  endtask

  function automatic bit local_pred();
    return m_q[m_q.size() - ORDER] ^ m_q[m_q.size() - TAP];
  endfunction

  task automatic model(input bit d, input bit e, input bit c);
    bit p;
    bit bad;
    bit any;
    exp_err = 1'b0;
    if (e) begin
      if (m_mode == 0) begin
        m_q.push_back(d);
        while (m_q.size() > ORDER) void'(m_q.pop_front());
        m_cnt++;
        if (m_cnt == ORDER) begin
          m_cnt = 0;
          any = 1'b0;
          foreach (m_q[i]) any |= m_q[i];
          if (any) m_mode = 1;
        end
      end else if (m_mode == 1) begin
        p = local_pred();
        m_q.push_back(p);
        void'(m_q.pop_front());
        if (d == p) begin
          m_cnt++;
          if (m_cnt == LOCK_CNT) begin
            m_mode = 2; m_cnt = 0; m_win = 0; m_werr = 0;
          end
        end else begin
          m_mode = 0; m_cnt = 0;
        end
      end else begin
        p = local_pred();
        m_q.push_back(p);
        void'(m_q.pop_front());
        bad = (d != p);
        exp_err = bad;
        if (bad && exp_cnt < CNT_MAX) exp_cnt++;
        if (m_win == WINDOW - 1) begin
          m_win = 0;
          m_werr = bad;
        end else begin
          m_win++;
          m_werr += bad;
        end
        if (m_werr >= LOSS) begin
          m_mode = 0; m_cnt = 0;
        end
      end
    end
    if (c) exp_cnt = 0;
    exp_locked = (m_mode == 2);
  endtask

  // One bit time: drive, clock, update reference, compare all outputs.
  task automatic step(input bit d, input bit e, input bit c);
    bus.data_in = d;
    bus.en      = e;
    bus.clr_cnt = c;
    @(posedge rx_clk);
    model(d, e, c);
    #1;
    cyc++;
    chk($sformatf("locked@%0d", cyc), 32'(bus.locked), 32'(exp_locked));
    chk($sformatf("err@%0d", cyc), 32'(bus.err), 32'(exp_err));
    chk($sformatf("err_cnt@%0d", cyc), 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  task automatic send(input bit flip, input bit e, input bit c);
    bit d;
    if (e) begin
      gen_next(d);
      d ^= flip;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    step(d, e, c);
  endtask

  // Move to the start of a window so injected errors land at known offsets.
  task automatic align();
    for (int k = 0; k < WINDOW && !(m_mode == 2 && m_win == 0); k++) send(1'b0, 1'b1, 1'b0);
    chk("align", 32'(m_mode == 2 && m_win == 0), 32'd1);
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge rx_clk) rst = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_at;
    int pulses;
    int pulse_at;

    rst = 1'b0;
    bus.data_in = 1'b0;
    bus.en      = 1'b0;
    bus.clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge rx_clk);
    do_reset();

    // Clean stream from reset: lock after ORDER+LOCK_CNT bits, no errors.
    gen_seed();
    lock_at = -1;
    for (int i = 1; i <= 1000; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (lock_at < 0 && bus.locked === 1'b1) lock_at = i;
    end
    chk("t1_lock_at", 32'(lock_at), 32'd23);
    chk("t1_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Single inverted bit: one err pulse reported right after that bit.
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 300; i++) begin
      send(i == 200, 1'b1, 1'b0);
      if (bus.err === 1'b1) begin pulses++; pulse_at = i; end
    end
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_pulse_at", 32'(pulse_at), 32'd200);
    chk("t2_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("t2_locked", 32'(bus.locked), 32'd1);

    // Four errors in one window: lock lost, then re-acquired in 23 bits.
    send(1'b0, 1'b1, 1'b1);
    align();
    for (int off = 0; off <= 45; off++)
      send(off == 3 || off == 17 || off == 30 || off == 45, 1'b1, 1'b0);
    chk("t3_locked_lost", 32'(bus.locked), 32'd0);
    chk("t3_err_cnt", 32'(bus.err_cnt), 32'd4);
    lock_at = -1;
    for (int i = 1; i <= 100; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (lock_at < 0 && bus.locked === 1'b1) lock_at = i;
    end
    chk("t3_relock_at", 32'(lock_at), 32'd23);

    // Three errors in each of two consecutive windows: lock held.
    send(1'b0, 1'b1, 1'b1);
    align();
    for (int off = 0; off < 2 * WINDOW; off++)
      send(off == 5 || off == 20 || off == 40 || off == 69 || off == 94 || off == 114, 1'b1, 1'b0);
    chk("t4_locked", 32'(bus.locked), 32'd1);
    chk("t4_err_cnt", 32'(bus.err_cnt), 32'd6);

    // Error on the wrap bit opens the next window at one.
    send(1'b0, 1'b1, 1'b1);
    align();
    for (int off = 0; off <= 84; off++)
      send(off == 10 || off == 20 || off == 63 || off == 74 || off == 84, 1'b1, 1'b0);
    chk("t4b_locked", 32'(bus.locked), 32'd1);
    chk("t4b_err_cnt", 32'(bus.err_cnt), 32'd5);
    for (int off = 85; off <= 94; off++) send(off == 94, 1'b1, 1'b0);
    chk("t4b_lost", 32'(bus.locked), 32'd0);
    chk("t4b_err_cnt2", 32'(bus.err_cnt), 32'd6);
    for (int i = 0; i < 40; i++) send(1'b0, 1'b1, 1'b0);
    chk("t4b_relocked", 32'(bus.locked), 32'd1);

    // Saturation: 20 errors spread two per window.
    align();
    for (int w = 0; w < 10; w++)
      for (int off = 0; off < WINDOW; off++)
        send(off == 10 || off == 40, 1'b1, 1'b0);
    chk("t6_sat", 32'(bus.err_cnt), 32'(CNT_MAX));
    chk("t6_locked", 32'(bus.locked), 32'd1);
    send(1'b1, 1'b1, 1'b1);
    chk("t6_clr_prio", 32'(bus.err_cnt), 32'd0);
    chk("t6_clr_err", 32'(bus.err), 32'd1);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b0);
    chk("t6_pre_rst_locked", 32'(bus.locked), 32'd1);
    do_reset();

    // Stuck-low line: never leaves seeding, then a real stream locks.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    chk("t5_locked", 32'(bus.locked), 32'd0);
    chk("t5_err_cnt", 32'(bus.err_cnt), 32'd0);
    gen_seed();
    for (int i = 0; i < 120; i++) send(1'b0, 1'b1, 1'b0);
    chk("t5_locked_after", 32'(bus.locked), 32'd1);

    // Random traffic: gaps in en, sporadic bit errors, clears and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        send($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
